// File: rtl/bios_burst_loader_pkg.sv
// ---------------------------------------------------------------------------
// bios_pkg
// Shared types for the burst boot loader: command opcodes, response bytes
// and the controller state encoding.
// ---------------------------------------------------------------------------
package bios_pkg;

   typedef enum logic [7:0] {
      OP_NOP         = 8'h00,
      OP_BOOT        = 8'h01,
      OP_RST         = 8'h02,
      OP_PING        = 8'h03,
      OP_SET_ADDR    = 8'h10,
      OP_WRITE_BURST = 8'h20,
      OP_READ_BURST  = 8'h30
   } opcode_e;

   localparam logic [7:0] RSP_ACK  = 8'hA5;
   localparam logic [7:0] RSP_PONG = 8'h5A;
   localparam logic [7:0] RSP_ERR  = 8'hEE;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_WDATA,
      S_WCOMMIT,
      S_RREQ,
      S_RWAIT,
      S_RSEND,
      S_SEND,
      S_RSTP,
      S_BOOTED
   } state_e;

endpackage

// File: rtl/bios_burst_loader_if.sv
// ---------------------------------------------------------------------------
// bios_burst_loader_if
// Byte-stream command/response pair plus the RAM second-port bus.
//   master : the loader (drives responses, RAM strobes/address/data)
//   slave  : the environment (UART byte pair and RAM)
// ---------------------------------------------------------------------------
interface bios_burst_loader_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned NB = DATA_WIDTH / 8;

   // command stream in
   logic [7:0]            i_data;
   logic                  i_valid;
   logic                  o_in_ready;
   // response stream out
   logic [7:0]            o_data;
   logic                  o_valid;
   logic                  i_out_ready;
   // RAM port
   logic                  o_read_req;
   logic [ADDR_WIDTH-1:0] o_read_addr;
   logic [DATA_WIDTH-1:0] i_read_data;
   logic                  o_write_enable;
   logic [NB-1:0]         o_byte_enable;
   logic [ADDR_WIDTH-1:0] o_write_addr;
   logic [DATA_WIDTH-1:0] o_write_data;

   modport master (
      input  i_data, i_valid, i_out_ready, i_read_data,
      output o_in_ready, o_data, o_valid, o_read_req, o_read_addr,
             o_write_enable, o_byte_enable, o_write_addr, o_write_data
   );

   modport slave (
      output i_data, i_valid, i_out_ready, i_read_data,
      input  o_in_ready, o_data, o_valid, o_read_req, o_read_addr,
             o_write_enable, o_byte_enable, o_write_addr, o_write_data
   );
endinterface

// File: rtl/bios_burst_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// bios_byte_packer
// Serial byte <-> word register with a byte counter.
//   i_push_le : write i_byte into lane o_cnt (little-endian assembly)
//   i_push_be : shift word left one byte, i_byte enters lane 0 (MSB first)
//   i_load    : parallel load of i_load_word
//   i_pop     : shift word right one byte (lane 0 is the byte on offer)
//   i_clr     : zero the counter (word untouched)
//   o_word / o_shl / o_next_byte / o_cnt : current word, word after a
//   big-endian push, byte that follows a pop, bytes handled so far
// ---------------------------------------------------------------------------
module bios_byte_packer #(
   parameter int unsigned PW = 32,
   localparam int unsigned PB = PW / 8,
   localparam int unsigned CW = $clog2(PB) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_load,
   input  logic          i_push_le,
   input  logic          i_push_be,
   input  logic          i_pop,
   input  logic [7:0]    i_byte,
   input  logic [PW-1:0] i_load_word,
   output logic [PW-1:0] o_word,
   output logic [PW-1:0] o_shl,
   output logic [7:0]    o_next_byte,
   output logic [CW-1:0] o_cnt
);
   logic [PW-1:0] r_word;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] w_shr;

   assign o_shl       = (r_word << 8) | PW'(i_byte);
   assign w_shr       = r_word >> 8;
   assign o_next_byte = w_shr[7:0];
   assign o_word      = r_word;
   assign o_cnt       = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else begin
         if (i_load) begin
            r_word <= i_load_word;
         end else if (i_push_le) begin
            for (int unsigned i = 0; i < PB; i++) begin
               if (r_cnt == CW'(i)) r_word[i*8 +: 8] <= i_byte;
            end
         end else if (i_push_be) begin
            r_word <= o_shl;
         end else if (i_pop) begin
            r_word <= w_shr;
         end

         if (i_clr || i_load)                   r_cnt <= '0;
         else if (i_push_le || i_push_be || i_pop) r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/bios_burst_loader.sv
// ---------------------------------------------------------------------------
// bios_burst_loader
// Byte-serial boot monitor: decodes commands from the byte stream, performs
// auto-incrementing burst writes/reads on the RAM port, answers PING,
// pulses the core reset and latches BOOT.
//   clk, rst_n (async, active low), clk_en (gates every state change)
//   o_rst    : core reset pulse (RST command)
//   o_booted : sticky, set by BOOT
//   bus      : byte streams + RAM port (master side)
// ---------------------------------------------------------------------------
module bios_burst_loader
   import bios_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned RST_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clk_en,
   output logic                    o_rst,
   output logic                    o_booted,
   bios_burst_loader_if.master     bus
);
   localparam int unsigned NB  = DATA_WIDTH / 8;
   localparam int unsigned NBA = ADDR_WIDTH / 8;
   localparam int unsigned PW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int unsigned CW  = $clog2(PW / 8) + 1;

   state_e                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_left;
   logic [3:0]            r_wait;
   logic [7:0]            r_rcnt;
   logic                  r_is_read;
   logic                  r_in_ready, r_valid, r_read_req, r_we, r_rst, r_booted;
   logic [7:0]            r_data;
   logic [NB-1:0]         r_be;

   logic                  w_in_beat, w_out_beat;
   logic                  w_push_le, w_push_be, w_pop, w_load, w_clr;
   logic                  w_data_last, w_addr_last;
   logic [PW-1:0]         w_word, w_shl;
   logic [7:0]            w_next_byte;
   logic [CW-1:0]         w_cnt;

   assign w_in_beat   = bus.i_valid & r_in_ready & clk_en;
   assign w_out_beat  = r_valid & bus.i_out_ready & clk_en;
   assign w_data_last = (w_cnt == CW'(NB - 1));
   assign w_addr_last = (w_cnt == CW'(NBA - 1));
   assign w_push_be   = w_in_beat & (r_state == S_ADDR);
   assign w_push_le   = w_in_beat & (r_state == S_WDATA);
   assign w_pop       = w_out_beat & (r_state == S_RSEND);
   assign w_load      = clk_en & (r_state == S_RWAIT) & (r_wait == 4'(RD_LATENCY - 1));
   // The counter restarts at the last byte of each field, so every field
   // starts from lane 0 without an explicit clear on entry.
   assign w_clr       = (w_push_be & w_addr_last) | ((w_push_le | w_pop) & w_data_last);

   bios_byte_packer #(.PW(PW)) u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (w_clr),
      .i_load      (w_load),
      .i_push_le   (w_push_le),
      .i_push_be   (w_push_be),
      .i_pop       (w_pop),
      .i_byte      (bus.i_data),
      .i_load_word (PW'(bus.i_read_data)),
      .o_word      (w_word),
      .o_shl       (w_shl),
      .o_next_byte (w_next_byte),
      .o_cnt       (w_cnt)
   );

   assign bus.o_in_ready     = r_in_ready;
   assign bus.o_valid        = r_valid;
   assign bus.o_data         = r_data;
   assign bus.o_read_req     = r_read_req;
   assign bus.o_read_addr    = r_addr;
   assign bus.o_write_addr   = r_addr;
   assign bus.o_write_enable = r_we;
   assign bus.o_byte_enable  = r_be;
   assign bus.o_write_data   = w_word[DATA_WIDTH-1:0];
   assign o_rst              = r_rst;
   assign o_booted           = r_booted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_left     <= '0;
         r_wait     <= '0;
         r_rcnt     <= '0;
         r_is_read  <= 1'b0;
         r_in_ready <= 1'b0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_read_req <= 1'b0;
         r_we       <= 1'b0;
         r_be       <= '0;
         r_rst      <= 1'b0;
         r_booted   <= 1'b0;
      end else if (clk_en) begin
         case (r_state)
            S_IDLE: begin
               r_in_ready <= 1'b1;
               if (w_in_beat) begin
                  case (bus.i_data)
                     OP_NOP: ;
                     OP_PING: begin
                        r_in_ready <= 1'b0;
                        r_valid    <= 1'b1;
                        r_data     <= RSP_PONG;
                        r_state    <= S_SEND;
                     end
                     OP_BOOT: begin
                        r_in_ready <= 1'b0;
                        r_booted   <= 1'b1;
                        r_state    <= S_BOOTED;
                     end
                     OP_RST: begin
                        r_in_ready <= 1'b0;
                        r_rst      <= 1'b1;
                        r_rcnt     <= '0;
                        r_state    <= S_RSTP;
                     end
                     OP_SET_ADDR: r_state <= S_ADDR;
                     OP_WRITE_BURST: begin
                        r_is_read <= 1'b0;
                        r_state   <= S_LEN;
                     end
                     OP_READ_BURST: begin
                        r_is_read <= 1'b1;
                        r_state   <= S_LEN;
                     end
                     default: begin
                        r_in_ready <= 1'b0;
                        r_valid    <= 1'b1;
                        r_data     <= RSP_ERR;
                        r_state    <= S_SEND;
                     end
                  endcase
               end
            end
            S_ADDR: begin
               if (w_in_beat && w_addr_last) begin
                  r_addr     <= w_shl[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(NB - 1);
                  r_in_ready <= 1'b0;
                  r_valid    <= 1'b1;
                  r_data     <= RSP_ACK;
                  r_state    <= S_SEND;
               end
            end
            S_LEN: begin
               if (w_in_beat) begin
                  r_left <= bus.i_data;
                  if (r_is_read) begin
                     r_in_ready <= 1'b0;
                     r_read_req <= 1'b1;
                     r_state    <= S_RREQ;
                  end else begin
                     r_state <= S_WDATA;
                  end
               end
            end
            S_WDATA: begin
               if (w_in_beat && w_data_last) begin
                  r_in_ready <= 1'b0;
                  r_we       <= 1'b1;
                  r_be       <= '1;
                  r_state    <= S_WCOMMIT;
               end
            end
            S_WCOMMIT: begin
               r_we   <= 1'b0;
               r_be   <= '0;
               r_addr <= r_addr + ADDR_WIDTH'(NB);
               if (r_left == 8'd0) begin
                  r_valid <= 1'b1;
                  r_data  <= RSP_ACK;
                  r_state <= S_SEND;
               end else begin
                  r_left     <= r_left - 8'd1;
                  r_in_ready <= 1'b1;
                  r_state    <= S_WDATA;
               end
            end
            S_RREQ: begin
               r_read_req <= 1'b0;
               r_wait     <= '0;
               r_state    <= S_RWAIT;
            end
            S_RWAIT: begin
               if (r_wait == 4'(RD_LATENCY - 1)) begin
                  r_valid <= 1'b1;
                  r_data  <= bus.i_read_data[7:0];
                  r_state <= S_RSEND;
               end else begin
                  r_wait <= r_wait + 4'd1;
               end
            end
            S_RSEND: begin
               if (w_out_beat) begin
                  if (w_data_last) begin
                     r_valid <= 1'b0;
                     r_addr  <= r_addr + ADDR_WIDTH'(NB);
                     if (r_left == 8'd0) begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                     end else begin
                        r_left     <= r_left - 8'd1;
                        r_read_req <= 1'b1;
                        r_state    <= S_RREQ;
                     end
                  end else begin
                     r_data <= w_next_byte;
                  end
               end
            end
            S_SEND: begin
               if (w_out_beat) begin
                  r_valid    <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            S_RSTP: begin
               if (r_rcnt == 8'(RST_CYCLES - 1)) begin
                  r_rst   <= 1'b0;
                  r_valid <= 1'b1;
                  r_data  <= RSP_ACK;
                  r_state <= S_SEND;
               end else begin
                  r_rcnt <= r_rcnt + 8'd1;
               end
            end
            S_BOOTED: ;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bios_burst_loader.sv
// ---------------------------------------------------------------------------
// tb_bios_burst_loader
// Scoreboard bench: command tasks push expected response bytes and expected
// RAM writes into queues from a word-level model (address + memory map);
// negedge monitors pop and compare whenever the DUT completes a beat.
// ---------------------------------------------------------------------------
module tb_bios_burst_loader;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned RSTC = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic clk_en = 1'b1;
   logic o_rst, o_booted;

   bios_burst_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   bios_burst_loader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .RST_CYCLES(RSTC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_en   (clk_en),
      .o_rst    (o_rst),
      .o_booted (o_booted),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s", nm);
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  exp_bytes[$];
   logic [63:0] exp_wr[$];
   logic [31:0] ram[logic [31:0]];
   logic [31:0] mdl[logic [31:0]];
   logic [31:0] mdl_addr = '0;
   logic [31:0] burst_words[$];
   int          exp_rst_pulses = 0;

   function automatic logic [31:0] seed_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction
   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : seed_word(a);
   endfunction
   function automatic logic [31:0] mdl_rd(input logic [31:0] a);
      return mdl.exists(a) ? mdl[a] : seed_word(a);
   endfunction

   // ---------------- environment drivers ----------------
   int en_mode = 0, rdy_mode = 0, gap_mode = 0;
   int beats = 0, stall_at = 0, stall_left = 0;

   always @(posedge clk) begin
      #1;
      clk_en = (en_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (rdy_mode)
         0: bus.i_out_ready = 1'b1;
         1: bus.i_out_ready = ($urandom_range(0, 2) != 0);
         default: begin
            if (beats == stall_at && stall_left > 0) begin
               bus.i_out_ready = 1'b0;
               stall_left--;
            end else begin
               bus.i_out_ready = 1'b1;
            end
         end
      endcase
   end

   // RAM with one enabled cycle of read latency; junk outside the valid slot
   always @(posedge clk) begin
      if (rst_n && clk_en) begin
         if (bus.o_read_req) bus.i_read_data <= ram_rd(bus.o_read_addr);
         else                bus.i_read_data <= $urandom;
         if (bus.o_write_enable) ram[bus.o_write_addr] = bus.o_write_data;
      end
   end

   // ---------------- monitors ----------------
   int rst_run = 0, rst_seen = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_valid) chk("in_ready_while_resp", bus.o_in_ready, 0);
         if (clk_en && bus.o_valid && bus.i_out_ready) begin
            beats++;
            if (exp_bytes.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL resp_unexpected: got %0h, expected none", bus.o_data);
            end else begin
               chk("resp_byte", bus.o_data, exp_bytes.pop_front());
            end
         end
         if (clk_en && bus.o_write_enable) begin
            chk("byte_enable", bus.o_byte_enable, 4'hF);
            if (exp_wr.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL write_unexpected: got %0h@%0h, expected none",
                        bus.o_write_data, bus.o_write_addr);
            end else begin
               chk("write_addr_data", {bus.o_write_addr, bus.o_write_data}, exp_wr.pop_front());
            end
         end
         if (o_rst && clk_en) rst_run++;
         if (!o_rst && rst_run != 0) begin
            chk("rst_pulse_len", rst_run, RSTC);
            rst_seen++;
            rst_run = 0;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      bit acc = 0;
      int t = 0;
      if (gap_mode != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.i_data  = b;
      bus.i_valid = 1'b1;
      while (!acc && t < 3000) begin
         @(negedge clk);
         acc = clk_en && bus.o_in_ready;
         t++;
      end
      if (!acc) fail_now("input_accept_timeout");
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_bytes.size() != 0 || exp_wr.size() != 0) && t < 5000) begin
         @(posedge clk); t++;
      end
      if (t >= 5000) fail_now("drain_timeout");
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic cmd_ping();
      exp_bytes.push_back(8'h5A);
      send_byte(8'h03);
   endtask

   task automatic cmd_set_addr(input logic [31:0] a);
      exp_bytes.push_back(8'hA5);
      mdl_addr = a & ~32'h3;
      send_byte(8'h10);
      for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
   endtask

   task automatic cmd_write();
      logic [31:0] w;
      foreach (burst_words[k]) begin
         exp_wr.push_back({mdl_addr, burst_words[k]});
         mdl[mdl_addr] = burst_words[k];
         mdl_addr += 32'd4;
      end
      exp_bytes.push_back(8'hA5);
      send_byte(8'h20);
      send_byte(8'(burst_words.size() - 1));
      foreach (burst_words[k]) begin
         w = burst_words[k];
         for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
      end
   endtask

   task automatic cmd_read(input int l);
      logic [31:0] w;
      for (int k = 0; k <= l; k++) begin
         w = mdl_rd(mdl_addr);
         for (int i = 0; i < 4; i++) exp_bytes.push_back(w[i*8 +: 8]);
         mdl_addr += 32'd4;
      end
      send_byte(8'h30);
      send_byte(8'(l));
   endtask

   task automatic cmd_bad(input logic [7:0] op);
      exp_bytes.push_back(8'hEE);
      send_byte(op);
   endtask

   task automatic cmd_rst();
      exp_bytes.push_back(8'hA5);
      exp_rst_pulses++;
      send_byte(8'h02);
   endtask

   task automatic random_burst(input int n);
      burst_words.delete();
      for (int k = 0; k < n; k++) burst_words.push_back($urandom);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_o_rst"},      o_rst, 0);
      chk({tag, "_o_booted"},   o_booted, 0);
      chk({tag, "_in_ready"},   bus.o_in_ready, 0);
      chk({tag, "_valid"},      bus.o_valid, 0);
      chk({tag, "_data"},       bus.o_data, 0);
      chk({tag, "_read_req"},   bus.o_read_req, 0);
      chk({tag, "_write_en"},   bus.o_write_enable, 0);
      chk({tag, "_byte_en"},    bus.o_byte_enable, 0);
      chk({tag, "_addr"},       bus.o_read_addr, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] op;
      int r, acc_after_boot;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.i_read_data = '0;
      ram[32'h100] = 32'hDEADBEEF;
      mdl[32'h100] = 32'hDEADBEEF;

      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      cmd_ping();
      wait_drain();

      // read with a 5-cycle stall after the second byte
      cmd_set_addr(32'h0000_0100);
      wait_drain();
      stall_at = beats + 2;
      stall_left = 5;
      rdy_mode = 2;
      cmd_read(0);
      wait_drain();
      rdy_mode = 0;

      // unaligned SET_ADDR is rounded down to 0x100
      cmd_set_addr(32'h0000_0103);
      burst_words = '{32'h44332211, 32'h88776655};
      cmd_write();
      wait_drain();

      // address wrap, then read back across the wrap
      cmd_set_addr(32'hFFFF_FFFC);
      random_burst(2);
      cmd_write();
      cmd_set_addr(32'hFFFF_FFFC);
      cmd_read(1);
      wait_drain();

      cmd_bad(8'h7F);
      cmd_rst();
      wait_drain();

      // randomized traffic with clk_en, ready and input gaps
      en_mode = 1; rdy_mode = 1; gap_mode = 1;
      repeat (40) begin
         r = $urandom_range(0, 9);
         case (r)
            0: cmd_ping();
            1: send_byte(8'h00);
            2: begin
               do op = 8'($urandom);
               while (op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h30});
               cmd_bad(op);
            end
            3, 4: cmd_set_addr(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : 32'($urandom_range(0, 4095)));
            5, 6: begin random_burst($urandom_range(1, 4)); cmd_write(); end
            7, 8: cmd_read($urandom_range(0, 3));
            default: cmd_rst();
         endcase
      end
      wait_drain();
      en_mode = 0; rdy_mode = 0; gap_mode = 0;
      wait_drain();

      // reset in the middle of a write word: nothing may be written
      cmd_set_addr(32'h0000_0200);
      wait_drain();
      send_byte(8'h20);
      send_byte(8'h03);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midburst");
      chk("midburst_wdata", bus.o_write_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mdl_addr = '0;
      cmd_ping();
      wait_drain();

      // BOOT is terminal
      send_byte(8'h01);
      repeat (3) @(posedge clk);
      #1;
      chk("boot_booted", o_booted, 1);
      chk("boot_in_ready", bus.o_in_ready, 0);
      chk("boot_o_rst", o_rst, 0);
      acc_after_boot = 0;
      bus.i_data = 8'h03;
      bus.i_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.o_in_ready) acc_after_boot++;
      end
      bus.i_valid = 1'b0;
      chk("boot_accepts", acc_after_boot, 0);
      chk("boot_still_booted", o_booted, 1);

      chk("rst_pulse_count", rst_seen, exp_rst_pulses);
      chk("leftover_resp", exp_bytes.size(), 0);
      chk("leftover_writes", exp_wr.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end
endmodule

// File: doc/bios_burst_loader.md
Name: bios_burst_loader

Overview:
- Byte-serial boot loader/monitor, next generation of the single-byte BIOS command block. Sits between the UART AXI-stream byte pair and the RAM's second port; holds the core in reset until a BOOT command.
- Adds parametrised address/data width, auto-incrementing burst writes/reads, a length field, a PING/ack and error-response protocol, and a timed reset pulse.

Parameters:
- ADDR_WIDTH, 32, RAM byte-address width; must be a multiple of 8.
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8, with NB = DATA_WIDTH/8 a power of two.
- RD_LATENCY, 1, enabled cycles from o_read_req to valid i_read_data (1..15).
- RST_CYCLES, 16, length of the o_rst pulse in enabled cycles (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  enable for all state advance; when low, state and outputs are held
- o_rst  out  1  core reset request
- o_booted  out  1  sticky, set by BOOT
- o_read_req  out  1  one-cycle read strobe
- o_read_addr  out  ADDR_WIDTH  word-aligned byte address
- i_read_data  in  DATA_WIDTH  RAM read word
- o_write_enable  out  1  one-cycle write strobe
- o_byte_enable  out  NB  byte lanes; all ones on every burst write
- o_write_addr  out  ADDR_WIDTH  equals o_read_addr
- o_write_data  out  DATA_WIDTH  assembled word
- i_data  in  8  command/data byte in
- i_valid  in  1  input valid
- o_in_ready  out  1  input ready
- o_data  out  8  response byte
- o_valid  out  1  response valid
- i_out_ready  in  1  response ready

Behaviour:
- Reset, asynchronous and active-low: state is IDLE, addr = 0, all strobes 0, o_rst = 0, o_booted = 0, o_valid = 0, o_data = 0, o_in_ready = 0.
- Input beat: i_valid & o_in_ready & clk_en.
- Output beat: o_valid & i_out_ready & clk_en. o_data and o_valid stay stable until the beat completes.
- o_in_ready is high only in IDLE, ADDR, LEN and WDATA.
- Opcodes (1 byte): 0x00 NOP, 0x01 BOOT, 0x02 RST, 0x03 PING, 0x10 SET_ADDR, 0x20 WRITE_BURST, 0x30 READ_BURST.
- Any other opcode: emit 0xEE, return to IDLE.
- State IDLE: on an input beat, decode the opcode.
  - NOP: stay in IDLE.
  - PING: go to SEND with 0x5A.
  - BOOT: go to BOOTED.
  - RST: go to RSTP.
  - SET_ADDR: go to ADDR.
  - WRITE_BURST / READ_BURST: go to LEN.
- State ADDR: take ADDR_WIDTH/8 bytes, MSB first, into a shift register. After the last byte, addr = value with the low log2(NB) bits cleared, then emit 0xA5.
- State LEN: one byte L; the burst is L+1 words (1..256). Next state is WDATA or RREQ.
- State WDATA: take NB bytes, little-endian into lanes 0..NB-1, then go to WCOMMIT.
- State WCOMMIT: drive o_write_enable = 1 for exactly one enabled cycle with o_write_data = assembled word.
  - Then addr += NB, wrapping mod 2^ADDR_WIDTH.
  - Decrement the count; if it reaches 0, emit 0xA5, otherwise return to WDATA.
- State RREQ: one-cycle o_read_req, then RWAIT for RD_LATENCY enabled cycles, then capture i_read_data.
- State RSEND: emit NB bytes, lane 0 first, each waiting on i_out_ready.
  - Then addr += NB (with wrap) and decrement the count.
  - Next state is RREQ, or IDLE when the count is done.
  - No trailing ack on reads.
- State SEND: hold the byte until the output beat, then go to IDLE.
- State RSTP: o_rst = 1 for RST_CYCLES enabled cycles, then emit 0xA5.
- State BOOTED: terminal. o_booted = 1, o_in_ready = 0, o_rst = 0, no strobes. Only rst_n exits it.
- A BOOT or RST byte arriving mid-burst is treated as data, not decoded; there is no abort other than rst_n.
- clk_en low during WCOMMIT or RREQ: the strobe is held for the whole low period and counts as one strobe.
- Address wrap: from 2^ADDR_WIDTH - NB, the next address is 0.
- Reset mid-burst: everything returns to reset values immediately. A partially assembled word is discarded and never written.

Decomposition:
- Package bios_pkg: opcode enum, response constants (ACK 0xA5, PONG 0x5A, ERR 0xEE), and the FSM state enum. The predecessor's opcode typedef is superseded by this package.
- One sub-module, bios_byte_packer: NB-byte serial-to-word assembler with a load/shift-out path and byte counter, used by both ADDR/WDATA and RSEND.

Test Plan:
- PING 0x03 -> exactly one output byte 0x5A; o_in_ready low until it is accepted.
- SET_ADDR 0x10 00 00 01 03, then WRITE_BURST 0x20 01 11 22 33 44 55 66 77 88 -> two write strobes: addr 0x100 data 0x44332211, then addr 0x104 data 0x88776655, byte_enable 0xF; then ack 0xA5.
- SET_ADDR 0x100, READ_BURST 0x30 00, RAM returns 0xDEADBEEF -> output EF BE AD DE; i_out_ready held low 5 cycles mid-stream with no byte lost or duplicated.
- SET_ADDR 0xFFFFFFFC, WRITE_BURST with L=1 -> writes at 0xFFFFFFFC then 0x00000000.
- Opcode 0x7F -> 0xEE. RST 0x02 -> o_rst high for exactly 16 enabled cycles, then 0xA5. BOOT 0x01 -> o_booted = 1 and further bytes are never accepted.
- rst_n asserted after 2 of 4 data bytes of a write -> no o_write_enable; all outputs at reset values asynchronously; next PING answered normally.
